// File: rtl/global_mem_responder_if.sv
// mem_if: per-channel valid/ready read and write request bundle between a cache's
// global-memory initiator (producer) and the memory model (consumer).
interface mem_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int CHANNELS  = 1
);
  logic [CHANNELS-1:0]                read_valid;
  logic [CHANNELS-1:0][ADDR_BITS-1:0] read_address;
  logic [CHANNELS-1:0]                write_valid;
  logic [CHANNELS-1:0][ADDR_BITS-1:0] write_address;
  logic [CHANNELS-1:0][DATA_BITS-1:0] write_data;
  logic [CHANNELS-1:0]                read_ready;
  logic [CHANNELS-1:0][DATA_BITS-1:0] read_data;
  logic [CHANNELS-1:0]                write_ready;

  modport consumer (
    input  read_valid, read_address, write_valid, write_address, write_data,
    output read_ready, read_data, write_ready
  );

  modport producer (
    output read_valid, read_address, write_valid, write_address, write_data,
    input  read_ready, read_data, write_ready
  );
endinterface

// File: rtl/global_mem_responder.sv
// Global data-memory model: round-robin over channels, one request in flight, ready pulses
// LATENCY cycles after accept; requesters hold valid until ready (a held valid is not re-served).
module global_mem_responder #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int CHANNELS      = 1,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2,
  localparam int CH_BITS      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  mem_if.consumer            mem_port,
  output logic               busy,
  output logic [CH_BITS-1:0] served_channel
);

  localparam int DEPTH    = 2 ** ADDR_BITS;
  localparam int MAX_LAT  = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_BITS = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_BITS-1:0] RD_LOAD = CNT_BITS'(READ_LATENCY - 1);
  localparam logic [CNT_BITS-1:0] WR_LOAD = CNT_BITS'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

  state_t                             state_q, state_d;
  logic [CHANNELS-1:0]                armed_q;
  logic [CHANNELS-1:0]                rd_rdy_q, wr_rdy_q;
  logic [CHANNELS-1:0][DATA_BITS-1:0] rd_dat_q;
  logic [CH_BITS-1:0]                 ch_q, last_q;
  logic                               op_wr_q;
  logic [ADDR_BITS-1:0]               addr_q;
  logic [DATA_BITS-1:0]               wdata_q;
  logic [CNT_BITS-1:0]                cnt_q;
  logic [DATA_BITS-1:0]               mem_q [DEPTH];

  logic [CHANNELS-1:0] eligible;
  logic                grant_vld;
  logic [CH_BITS-1:0]  grant_ch;
  logic                accept;
  logic                accept_wr;
  int                  idx;

  assign eligible = armed_q & (mem_port.read_valid | mem_port.write_valid);

  // Search starts one past the last winner so every channel gets a turn.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = 0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = (int'(last_q) + i) % CHANNELS;
      if (!grant_vld && eligible[idx]) begin
        grant_vld = 1'b1;
        grant_ch  = CH_BITS'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    // A channel with both valids gets its read served first.
    accept_wr = !mem_port.read_valid[grant_ch];
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = RESPOND;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      armed_q  <= '1;
      rd_rdy_q <= '0;
      wr_rdy_q <= '0;
      rd_dat_q <= '0;
      ch_q     <= '0;
      last_q   <= '0;
      op_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ch_q    <= grant_ch;
        last_q  <= grant_ch;
        op_wr_q <= accept_wr;
        addr_q  <= accept_wr ? mem_port.write_address[grant_ch] : mem_port.read_address[grant_ch];
        wdata_q <= mem_port.write_data[grant_ch];
        cnt_q   <= accept_wr ? WR_LOAD : RD_LOAD;
      end
      if (state_q == BUSY) begin
        if (cnt_q == '0) begin
          if (op_wr_q) begin
            mem_q[addr_q]  <= wdata_q;
            wr_rdy_q[ch_q] <= 1'b1;
          end else begin
            rd_rdy_q[ch_q] <= 1'b1;
            rd_dat_q[ch_q] <= mem_q[addr_q];
          end
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
      if (state_q == RESPOND) begin
        rd_rdy_q      <= '0;
        wr_rdy_q      <= '0;
        rd_dat_q      <= '0;
        armed_q[ch_q] <= 1'b0;
      end
      // Re-arm wins over the clear: a requester already idle is ready for a fresh request.
      for (int c = 0; c < CHANNELS; c++) begin
        if (!mem_port.read_valid[c] && !mem_port.write_valid[c]) armed_q[c] <= 1'b1;
      end
    end
  end

  assign mem_port.read_ready  = rd_rdy_q;
  assign mem_port.write_ready = wr_rdy_q;
  assign mem_port.read_data   = rd_dat_q;
  assign busy                 = (state_q != IDLE);
  assign served_channel       = ch_q;

endmodule

// File: tb/tb_global_mem_responder.sv
// Directed bench for global_mem_responder: four instances cover the default, 4-channel
// and two latency configurations.
module tb_global_mem_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  mem_if #(.ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(1)) ma ();
  mem_if #(.ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(4)) mb ();
  mem_if #(.ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(1)) mc ();
  mem_if #(.ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(1)) md ();

  logic       busy_a, busy_b, busy_c, busy_d;
  logic       served_a, served_c, served_d;
  logic [1:0] served_b;

  global_mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(1),
                         .READ_LATENCY(2), .WRITE_LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .mem_port(ma), .busy(busy_a), .served_channel(served_a));
  global_mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(4),
                         .READ_LATENCY(2), .WRITE_LATENCY(2)) dut_b (
    .clk(clk), .reset(reset), .mem_port(mb), .busy(busy_b), .served_channel(served_b));
  global_mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(1),
                         .READ_LATENCY(1), .WRITE_LATENCY(3)) dut_c (
    .clk(clk), .reset(reset), .mem_port(mc), .busy(busy_c), .served_channel(served_c));
  global_mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(1),
                         .READ_LATENCY(5), .WRITE_LATENCY(2)) dut_d (
    .clk(clk), .reset(reset), .mem_port(md), .busy(busy_d), .served_channel(served_d));

  task automatic set_req(input int d, input logic [1:0] ch, input logic rv, input logic wv,
                         input logic [7:0] addr, input logic [7:0] data);
    case (d)
      0: begin
        ma.read_valid[0] = rv; ma.write_valid[0] = wv;
        ma.read_address[0] = addr; ma.write_address[0] = addr; ma.write_data[0] = data;
      end
      1: begin
        mb.read_valid[ch] = rv; mb.write_valid[ch] = wv;
        mb.read_address[ch] = addr; mb.write_address[ch] = addr; mb.write_data[ch] = data;
      end
      2: begin
        mc.read_valid[0] = rv; mc.write_valid[0] = wv;
        mc.read_address[0] = addr; mc.write_address[0] = addr; mc.write_data[0] = data;
      end
      default: begin
        md.read_valid[0] = rv; md.write_valid[0] = wv;
        md.read_address[0] = addr; md.write_address[0] = addr; md.write_data[0] = data;
      end
    endcase
  endtask

  function automatic logic get_rr(input int d, input logic [1:0] ch);
    case (d)
      0: return ma.read_ready[0];
      1: return mb.read_ready[ch];
      2: return mc.read_ready[0];
      default: return md.read_ready[0];
    endcase
  endfunction

  function automatic logic get_wr(input int d, input logic [1:0] ch);
    case (d)
      0: return ma.write_ready[0];
      1: return mb.write_ready[ch];
      2: return mc.write_ready[0];
      default: return md.write_ready[0];
    endcase
  endfunction

  function automatic logic [7:0] get_rd(input int d, input logic [1:0] ch);
    case (d)
      0: return ma.read_data[0];
      1: return mb.read_data[ch];
      2: return mc.read_data[0];
      default: return md.read_data[0];
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0: return busy_a;
      1: return busy_b;
      2: return busy_c;
      default: return busy_d;
    endcase
  endfunction

  // Issues one request at a negedge and follows it to its ready pulse; ready is expected
  // in the cycle after edge accept+lat, i.e. at the lat-th negedge after the accept edge.
  task automatic do_op(input int d, input logic [1:0] ch, input logic wr, input logic [7:0] addr,
                       input logic [7:0] data, input int lat, input logic [7:0] exp_rd,
                       input logic hold, input string name, output int stamp);
    int   got  = -1;
    logic leak = 1'b0;
    set_req(d, ch, !wr, wr, addr, data);
    for (int k = 0; k < lat + 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (get_busy(d) !== 1'b1) $display("FAIL %s busy_after_accept: got %b want 1", name, get_busy(d));
        else passes++;
      end
      if ((wr ? get_wr(d, ch) : get_rr(d, ch)) === 1'b1) begin
        got = k;
        break;
      end
      if (get_rd(d, ch) !== 8'h00) leak = 1'b1;
    end
    stamp = cyc;
    checks++;
    if (got !== lat) $display("FAIL %s latency: got %0d want %0d", name, got, lat);
    else passes++;
    if (!wr) begin
      checks++;
      if (get_rd(d, ch) !== exp_rd) $display("FAIL %s read_data: got %h want %h", name, get_rd(d, ch), exp_rd);
      else passes++;
      checks++;
      if (leak) $display("FAIL %s read_data_before_ready: got nonzero want 00", name);
      else passes++;
    end
    if (!hold) set_req(d, ch, 1'b0, 1'b0, addr, data);
    @(negedge clk);
    checks++;
    if ({get_rr(d, ch), get_wr(d, ch), get_rd(d, ch)} !== 10'h0)
      $display("FAIL %s after_pulse: got rr=%b wr=%b rd=%h want 0", name, get_rr(d, ch), get_wr(d, ch), get_rd(d, ch));
    else passes++;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy_a, busy_b, busy_c, busy_d} !== 4'b0)
      $display("FAIL reset_busy: got %b want 0000", {busy_a, busy_b, busy_c, busy_d});
    else passes++;
    checks++;
    if ({ma.read_ready, ma.write_ready, mb.read_ready, mb.write_ready,
         mc.read_ready, mc.write_ready, md.read_ready, md.write_ready} !== 14'h0)
      $display("FAIL reset_ready: got nonzero want 0");
    else passes++;
    checks++;
    if ({ma.read_data, mb.read_data, mc.read_data, md.read_data} !== 56'h0)
      $display("FAIL reset_read_data: got nonzero want 0");
    else passes++;
    checks++;
    if ({served_a, served_b, served_c, served_d} !== 5'b0)
      $display("FAIL reset_served: got %b want 0", {served_a, served_b, served_c, served_d});
    else passes++;
  endtask

  task automatic test_reset_mid_busy();
    int st;
    int bad = 0;
    set_req(0, 2'd0, 1'b0, 1'b1, 8'h10, 8'hAB);
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b1) $display("FAIL midrst_accept: got busy %b want 1", busy_a);
    else passes++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy_a, ma.write_ready[0], ma.read_ready[0], ma.read_data[0]} !== 11'h0)
      $display("FAIL midrst_outputs: got busy=%b wr=%b rd=%h want 0", busy_a, ma.write_ready[0], ma.read_data[0]);
    else passes++;
    set_req(0, 2'd0, 1'b0, 1'b0, 8'h10, 8'hAB);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ma.write_ready[0] || busy_a) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL midrst_no_pulse: got %0d active cycles want 0", bad);
    else passes++;
    do_op(0, 2'd0, 1'b0, 8'h10, 8'h00, 2, 8'h00, 1'b0, "midrst_read", st);
  endtask

  task automatic test_write_read();
    int st;
    do_op(0, 2'd0, 1'b1, 8'h21, 8'h5A, 2, 8'h00, 1'b0, "wr_0x21", st);
    do_op(0, 2'd0, 1'b0, 8'h21, 8'h00, 2, 8'h5A, 1'b0, "rd_0x21", st);
  endtask

  task automatic test_sticky();
    int st;
    int extra = 0;
    do_op(0, 2'd0, 1'b1, 8'h03, 8'h3C, 2, 8'h00, 1'b0, "sticky_wr", st);
    do_op(0, 2'd0, 1'b0, 8'h03, 8'h00, 2, 8'h3C, 1'b1, "sticky_rd", st);
    repeat (3) begin
      @(negedge clk);
      if (busy_a || ma.read_ready[0]) extra++;
    end
    checks++;
    if (extra !== 0) $display("FAIL sticky_no_reserve: got %0d active cycles want 0", extra);
    else passes++;
    set_req(0, 2'd0, 1'b0, 1'b0, 8'h03, 8'h00);
    @(negedge clk);
    do_op(0, 2'd0, 1'b0, 8'h03, 8'h00, 2, 8'h3C, 1'b0, "sticky_rd2", st);
  endtask

  task automatic test_round_robin();
    int st;
    int n = 0;
    int order [3] = '{-1, -1, -1};
    logic [7:0] exp_d  [4] = '{8'hA0, 8'h00, 8'hB2, 8'hC3};
    logic [7:0] addr_t [4] = '{8'h01, 8'h00, 8'h02, 8'h03};
    do_op(1, 2'd2, 1'b1, 8'h02, 8'hB2, 2, 8'h00, 1'b0, "rr_w2", st);
    do_op(1, 2'd3, 1'b1, 8'h03, 8'hC3, 2, 8'h00, 1'b0, "rr_w3", st);
    do_op(1, 2'd0, 1'b1, 8'h01, 8'hA0, 2, 8'h00, 1'b0, "rr_w0", st);
    set_req(1, 2'd0, 1'b1, 1'b0, 8'h01, 8'h00);
    set_req(1, 2'd2, 1'b1, 1'b0, 8'h02, 8'h00);
    set_req(1, 2'd3, 1'b1, 1'b0, 8'h03, 8'h00);
    for (int k = 0; k < 40 && n < 3; k++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (mb.read_ready[c] === 1'b1) begin
          logic others;
          others = 1'b0;
          for (int o = 0; o < 4; o++)
            if (o != c && (mb.read_ready[o] !== 1'b0 || mb.read_data[o] !== 8'h00)) others = 1'b1;
          checks++;
          if (others || mb.write_ready !== 4'b0)
            $display("FAIL rr_only_ch%0d: got rr=%b wr=%b want single pulse", c, mb.read_ready, mb.write_ready);
          else passes++;
          checks++;
          if (served_b !== 2'(c)) $display("FAIL rr_served: got %0d want %0d", served_b, c);
          else passes++;
          checks++;
          if (mb.read_data[c] !== exp_d[c])
            $display("FAIL rr_data_ch%0d: got %h want %h", c, mb.read_data[c], exp_d[c]);
          else passes++;
          if (n < 3) order[n] = c;
          n++;
          set_req(1, 2'(c), 1'b0, 1'b0, addr_t[c], 8'h00);
        end
      end
    end
    checks++;
    if (n !== 3 || order[0] !== 2 || order[1] !== 3 || order[2] !== 0)
      $display("FAIL rr_order: got n=%0d %0d,%0d,%0d want 2,3,0", n, order[0], order[1], order[2]);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int st;
    int got = -1;
    do_op(1, 2'd1, 1'b1, 8'h40, 8'h11, 2, 8'h00, 1'b0, "sim_pre", st);
    set_req(1, 2'd1, 1'b1, 1'b1, 8'h40, 8'h77);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (mb.read_ready[1] === 1'b1 || mb.write_ready[1] === 1'b1) begin
        got = k;
        break;
      end
    end
    checks++;
    if (got !== 2 || mb.read_ready[1] !== 1'b1 || mb.write_ready[1] !== 1'b0)
      $display("FAIL sim_read_first: got k=%0d rr=%b wr=%b want k=2 rr=1 wr=0", got, mb.read_ready[1], mb.write_ready[1]);
    else passes++;
    checks++;
    if (mb.read_data[1] !== 8'h11) $display("FAIL sim_old_data: got %h want 11", mb.read_data[1]);
    else passes++;
    set_req(1, 2'd1, 1'b0, 1'b0, 8'h40, 8'h77);
    @(negedge clk);
    do_op(1, 2'd1, 1'b1, 8'h40, 8'h77, 2, 8'h00, 1'b0, "sim_wr", st);
    do_op(1, 2'd1, 1'b0, 8'h40, 8'h00, 2, 8'h77, 1'b0, "sim_rd", st);
  endtask

  task automatic test_latency();
    int s0, s1, s2, s3, s4;
    do_op(2, 2'd0, 1'b1, 8'h07, 8'h99, 3, 8'h00, 1'b0, "lat_w3a", s0);
    do_op(2, 2'd0, 1'b1, 8'h08, 8'h98, 3, 8'h00, 1'b0, "lat_w3b", s1);
    checks++;
    if (s1 - s0 !== 5) $display("FAIL lat_w3_spacing: got %0d want 5", s1 - s0);
    else passes++;
    do_op(2, 2'd0, 1'b0, 8'h07, 8'h00, 1, 8'h99, 1'b0, "lat_r1a", s1);
    do_op(2, 2'd0, 1'b0, 8'h08, 8'h00, 1, 8'h98, 1'b0, "lat_r1b", s2);
    checks++;
    if (s2 - s1 !== 3) $display("FAIL lat_r1_spacing: got %0d want 3", s2 - s1);
    else passes++;
    do_op(3, 2'd0, 1'b1, 8'h0F, 8'h5E, 2, 8'h00, 1'b0, "lat_w2d", s0);
    do_op(3, 2'd0, 1'b0, 8'h0F, 8'h00, 5, 8'h5E, 1'b0, "lat_r5a", s3);
    do_op(3, 2'd0, 1'b0, 8'hFF, 8'h00, 5, 8'h00, 1'b0, "lat_r5b", s4);
    checks++;
    if (s4 - s3 !== 7) $display("FAIL lat_r5_spacing: got %0d want 7", s4 - s3);
    else passes++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < 4; c++) set_req(d, 2'(c), 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_reset_mid_busy();
    test_write_read();
    test_sticky();
    test_round_robin();
    test_simultaneous();
    test_latency();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/global_mem_responder.md
# global_mem_responder

Responder end of the `mem_if` valid/ready protocol: the global data-memory model that answers read and write requests from the cache's global-memory port (one or more requester channels). It holds a DEPTH-word storage array, arbitrates round-robin across channels, and services one request at a time with a programmable fixed latency. It sits below the cache in the memory hierarchy and is the memory-side counterpart of the cache's `data_mem_if` initiator.

## Interface
- ADDR_BITS, 8, address width
- DATA_BITS, 8, word width
- CHANNELS, 1, requester channels on the interface
- READ_LATENCY, 2, cycles from accept edge to read_ready pulse; legal range ≥1
- WRITE_LATENCY, 2, cycles from accept edge to write_ready pulse; legal range ≥1
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high
- mem_port  mem_if.consumer  -  per channel c: read_valid[c], read_address[c] (ADDR_BITS), write_valid[c], write_address[c] (ADDR_BITS), write_data[c] (DATA_BITS) in; read_ready[c], read_data[c] (DATA_BITS), write_ready[c] out
- busy  output  1  high while a request is in service (BUSY or RESPOND)
- served_channel  output  $clog2(CHANNELS) (min 1)  channel latched at the most recent accept

## Operation
- Storage: 2**ADDR_BITS words, zeroed on reset.
- Per-channel `armed` bit, reset to 1. Cleared when that channel's ready pulses; set on any edge where the channel's read_valid and write_valid are both sampled 0. Prevents re-serving a request whose valid is still high the cycle after ready.
- Eligible channel: armed and (read_valid or write_valid).
- Arbitration: round-robin pointer `last`, reset 0. In IDLE, search channels last+1 … last+CHANNELS (mod CHANNELS); first eligible wins; `last` ← winner at accept.
- Same channel read_valid and write_valid both high: read served first; write served in a later transaction.
- FSM:
  - IDLE: if any eligible channel, accept: latch channel, op, address, write data; load counter with LATENCY-1 of op; → BUSY. Otherwise stay.
  - BUSY: counter decrements each cycle; at counter==0 → RESPOND (ready registered high on that edge).
  - RESPOND (one cycle): ready[served]=1. Read: read_data[served] = storage[addr], registered on entry edge. Write: storage[addr] ← data on entry edge. Exit edge: ready ← 0, armed[served] ← 0, → IDLE.
- Non-served channels: ready 0, read_data 0 at all times. read_data of served channel returns to 0 when ready drops.
- Read-after-write ordering is strict: a single engine means a read accepted after a write's RESPOND sees the written value.
- Arithmetic: address used unmodified; no wrap or bounds logic (full range mapped).

## Timing
- Reset (async, any state, mid-transaction included): state IDLE, all read_ready/write_ready 0, all read_data 0, busy 0, served_channel 0, last 0, armed all 1, storage 0. Aborted request is not completed; requester must re-issue.
- Accept edge E0 (valid sampled in IDLE). Ready high in the cycle after edge E0+LATENCY, for exactly one cycle.
- busy high from E0+1 cycle through RESPOND cycle inclusive.
- Back-to-back: next accept earliest at the edge following the RESPOND cycle's end; throughput LATENCY+2 cycles per request.
- Requester dropping valid before ready: the request is still completed (already latched); write is still committed.
- Requester holding valid after ready: not re-served until valid seen low once (armed).

## Test plan
- Reset mid-BUSY: write to 0x10 accepted, reset asserted before ready -> ready never pulses, storage[0x10]=0, busy=0, all outputs 0 immediately.
- Write then read, CHANNELS=1, latencies 2: write 0x5A to 0x21, hold valid until ready, drop -> write_ready one-cycle pulse 2 cycles after accept; subsequent read of 0x21 -> read_ready pulse with read_data=0x5A, 0 on other cycles.
- Sticky valid: read of 0x03 with read_valid held high 4 cycles past ready -> exactly one read_ready pulse; second request accepted only after valid low one cycle.
- Round-robin, CHANNELS=4: channels 0,2,3 post reads simultaneously, last=0 -> service order 2,3,0; served_channel tracks 2,3,0; each ready pulse on its own channel only.
- Latency sweep: READ_LATENCY=1 and 5, WRITE_LATENCY=3 -> ready at accept+1, +5, +3 cycles respectively; back-to-back spacing LATENCY+2.
- Simultaneous read_valid and write_valid on channel 1 (addr 0x40, data 0x77, storage 0x11) -> read served first returning 0x11, then write committed; later read returns 0x77.
